// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes,
// FSM state encoding and a helper for sizing the word index.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic int word_idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 32-bit storage word and a sub-word access:
// load extraction/extension, store byte mask, replicated store data, misalign flag.
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] raw_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  byte_mask,
  output logic [31:0] store_data,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted = raw_word >> {addr_lo, 3'b000};

  // Store data is replicated across lanes so the mask alone picks the target bytes.
  always_comb begin
    byte_mask  = 4'b0000;
    store_data = 32'h0;
    misalign   = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        byte_mask  = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        misalign   = addr_lo[0];
        byte_mask  = 4'b0011 << addr_lo;
        store_data = {2{wdata[15:0]}};
      end
      2'b10: begin
        misalign   = (addr_lo != 2'b00);
        byte_mask  = 4'b1111;
        store_data = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      F3_W:    load_data = shifted;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding load/store, accepted and
// answered through valid/ready handshakes, with busy raised while in flight.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IW = word_idx_width(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state;
  logic [3:0]    cnt;
  logic          wr_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;

  logic [IW-1:0] idx;
  logic [31:0]   raw_word;
  logic [31:0]   load_data;
  logic [3:0]    byte_mask;
  logic [31:0]   store_data;
  logic          misalign;
  logic          illegal;
  logic          out_of_range;
  logic          acc_err;
  logic          do_access;

  assign idx          = addr_q[IW+1:2];
  assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
  assign raw_word     = out_of_range ? 32'h0 : mem[idx];
  assign acc_err      = illegal | misalign | out_of_range;
  assign do_access    = (state == ST_WAIT) && (cnt == 4'd0);

  // Unsigned variants exist only for loads.
  always_comb begin
    illegal = 1'b1;
    case (f3_q)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = wr_q;
      default:          illegal = 1'b1;
    endcase
  end

  dmem_lane_align u_align (
    .addr_lo    (addr_q[1:0]),
    .funct3     (f3_q),
    .raw_word   (raw_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .byte_mask  (byte_mask),
    .store_data (store_data),
    .misalign   (misalign)
  );

  // Storage is never reset; a reset in the commit cycle suppresses the store.
  always_ff @(posedge clk) begin
    if (!rst && do_access && wr_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_mask[b]) mem[idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      f3_q      <= 3'b000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q      <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            f3_q      <= req_funct3;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || wr_q) ? 32'h0 : load_data;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        rsp_ready = 1'b1;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  always @(posedge clk) cycle++;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [0:DEPTH*4-1];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: little-endian byte array, errors decided from the access rules.
  function automatic void model_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                                   input logic [2:0] f, output logic [31:0] rd, output logic e);
    int     size;
    bit     legal;
    longint val;
    int     ai;
    size  = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    e     = !legal || ((a % size) != 0) || ((a >> 2) >= DEPTH);
    rd    = 32'h0;
    if (e) return;
    ai = int'(a);
    if (w) begin
      for (int i = 0; i < size; i++) mdl[ai+i] = d[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < size; i++) val += longint'(mdl[ai+i]) << (8*i);
      if (!f[2] && size < 4 && mdl[ai+size-1][7]) val -= (longint'(1) << (8*size));
      rd = val[31:0];
    end
  endfunction

  // Monitor: latency on first valid, data/err on handshake, busy mirrors !req_ready.
  bit   seen = 1'b0;
  exp_t popped;
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else begin
      check_val("busy_vs_ready", {31'h0, busy}, {31'h0, ~req_ready});
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rsp: got rdata 0x%08h with no request pending", rsp_rdata);
        end else begin
          if (!seen) begin
            check_val({sb[0].name, "_lat"}, 32'(cycle - sb[0].acc), 32'(LAT));
            seen = 1'b1;
          end
          if (rsp_ready) begin
            popped = sb.pop_front();
            check_val({popped.name, "_rdata"}, rsp_rdata, popped.rdata);
            check_val({popped.name, "_err"}, {31'h0, rsp_err}, {31'h0, popped.err});
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f, input string name, input bit expect_rsp);
    int          n;
    logic [31:0] rd;
    logic        e;
    n = 0;
    while (!req_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s_accept_timeout: req_ready=%0b required 1", name, req_ready);
        return;
      end
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (expect_rsp) begin
      model_op(w, a, d, f, rd, e);
      sb.push_back('{rdata: rd, err: e, acc: cycle, name: name});
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 || !req_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s_drain_timeout: pending=%0d required 0", name, sb.size());
        return;
      end
    end
  endtask

  task automatic checkOutput(input string name);
    check_val({name, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    check_val({name, "_busy"}, {31'h0, busy}, 32'h0);
    check_val({name, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    check_val({name, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check_val({name, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] exp_bp;
    int          n;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_start");

    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 32'(i * 4), $urandom, F3_W, $sformatf("init%0d", i), 1'b1);
    wait_idle("init");

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, F3_W, "sw_10", 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0, F3_W, "lw_10", 1'b1);
    applyStimulus(1'b0, 32'h13, 32'h0, F3_B, "lb_13", 1'b1);
    applyStimulus(1'b0, 32'h13, 32'h0, F3_BU, "lbu_13", 1'b1);
    applyStimulus(1'b0, 32'h12, 32'h0, F3_H, "lh_12", 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0, F3_HU, "lhu_10", 1'b1);
    applyStimulus(1'b1, 32'h11, 32'h00000055, F3_B, "sb_11", 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0, F3_W, "lw_10_partial", 1'b1);
    applyStimulus(1'b0, 32'h12, 32'h0, F3_W, "lw_misalign", 1'b1);
    applyStimulus(1'b1, 32'h13, 32'hFFFFFFFF, F3_H, "sh_misalign", 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0, F3_W, "lw_10_after_err", 1'b1);
    applyStimulus(1'b0, 32'(DEPTH * 4), 32'h0, F3_W, "lw_oor", 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b011, "f3_illegal", 1'b1);
    wait_idle("directed");

    // Reset while idle must clear the response registers left by the last load.
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_idle");

    // Backpressure: hold the response, offer a competing store that must be ignored.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0, F3_W, "bp_lw", 1'b1);
    exp_bp = sb[0].rdata;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    req_funct3 = F3_W;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check_val("bp_rsp_rdata", rsp_rdata, exp_bp);
      check_val("bp_rsp_err", {31'h0, rsp_err}, 32'h0);
      check_val("bp_req_ready", {31'h0, req_ready}, 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("bp");
    applyStimulus(1'b0, 32'h10, 32'h0, F3_W, "lw_after_bp", 1'b1);
    wait_idle("after_bp");

    // Reset in WAIT aborts the store; the old word must survive.
    applyStimulus(1'b1, 32'h20, 32'h12345678, F3_W, "sw_abort", 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_val("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_val("abort_req_ready", {31'h0, req_ready}, 32'h1);
    applyStimulus(1'b0, 32'h20, 32'h0, F3_W, "lw_20_after_abort", 1'b1);
    wait_idle("abort");

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4 + $urandom_range(0, 255));
      else a = 32'($urandom_range(0, 63));
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                    $sformatf("rand%0d", i), 1'b1);
    end
    wait_idle("random");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
